// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution front-end control blocks:
// FSM encoding, frame-size limits and default bus widths.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FEED  = 2'b01,
    ST_FLUSH = 2'b11
  } feed_state_e;

  localparam int MAX_IMG_DIM = 416;
  localparam int MIN_ROW_IN  = 4;
  localparam int MIN_COL_IN  = 2;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ROW_W  = 9;
  localparam int DEF_COL_W  = 9;

  function automatic logic size_legal(input int rows, input int cols);
    return (rows >= MIN_ROW_IN) && (cols >= MIN_COL_IN) && (cols <= MAX_IMG_DIM);
  endfunction

endpackage

// File: rtl/line_feed_ctrl_scan_counter.sv
// Row/column scan position of the next beat to emit, with decodes for the
// last real pixel and the last flush beat of a frame.
module scan_counter #(
  parameter int MaxRowWidth = 9,
  parameter int MaxColWidth = 9
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [MaxRowWidth-1:0] row_lim,
  input  logic [MaxColWidth-1:0] col_lim,
  output logic [MaxRowWidth-1:0] row,
  output logic [MaxColWidth-1:0] col,
  output logic                   last_pixel,
  output logic                   last_flush
);

  localparam logic [MaxRowWidth:0]   RowOneX = 1;
  localparam logic [MaxColWidth:0]   ColOneX = 1;
  localparam logic [MaxRowWidth-1:0] RowInc  = 1;
  localparam logic [MaxColWidth-1:0] ColInc  = 1;

  logic [MaxRowWidth-1:0] row_q, row_d;
  logic [MaxColWidth-1:0] col_q, col_d;
  logic [MaxRowWidth:0]   row_end;
  logic [MaxColWidth:0]   col_last_px;
  logic [MaxColWidth:0]   col_end;
  logic                   row_wrap;

  // Limits are widened by one bit so col_lim+1 = 417 cannot wrap.
  always_comb begin
    row_end     = {1'b0, row_lim} - RowOneX;
    col_last_px = {1'b0, col_lim} - ColOneX;
    col_end     = {1'b0, col_lim} + ColOneX;
    row_wrap    = ({1'b0, row_q} == row_end);
    last_pixel  = row_wrap && ({1'b0, col_q} == col_last_px);
    last_flush  = ({1'b0, row_q} == RowOneX) && ({1'b0, col_q} == col_end);

    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (enable) begin
      if (row_wrap) begin
        row_d = '0;
        col_d = col_q + ColInc;
      end else begin
        row_d = row_q + RowInc;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/line_feed_ctrl.sv
// Upstream feeder for the 3x3 line buffer: one beat per clock while a frame
// is active, real pixels first, then zero beats that drain the bottom padding.
module line_feed_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int DataWidth   = DEF_DATA_W,
  parameter int MaxRowWidth = DEF_ROW_W,
  parameter int MaxColWidth = DEF_COL_W
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   start,
  input  logic [MaxRowWidth-1:0] row_in,
  input  logic [MaxColWidth-1:0] col_in,
  input  logic [DataWidth-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DataWidth-1:0]   data_out,
  output logic [MaxRowWidth-1:0] row_count,
  output logic [MaxColWidth-1:0] col_count,
  output logic                   beat_active,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  feed_state_e state_q, state_d;

  logic [MaxRowWidth-1:0] row_lim_q, row_lim_d;
  logic [MaxColWidth-1:0] col_lim_q, col_lim_d;
  logic [DataWidth-1:0]   data_out_q, data_out_d;
  logic [MaxRowWidth-1:0] row_count_q, row_count_d;
  logic [MaxColWidth-1:0] col_count_q, col_count_d;
  logic                   beat_active_q, beat_active_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   start_ok, start_bad, cnt_en;
  logic [MaxRowWidth-1:0] pos_row;
  logic [MaxColWidth-1:0] pos_col;
  logic                   last_pixel, last_flush;

  always_comb begin
    start_ok  = start && (state_q == ST_IDLE) && size_legal(int'(row_in), int'(col_in));
    start_bad = start && (state_q == ST_IDLE) && !size_legal(int'(row_in), int'(col_in));
  end

  scan_counter #(
    .MaxRowWidth(MaxRowWidth),
    .MaxColWidth(MaxColWidth)
  ) u_scan (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .enable    (cnt_en),
    .clear     (start_ok),
    .row_lim   (row_lim_q),
    .col_lim   (col_lim_q),
    .row       (pos_row),
    .col       (pos_col),
    .last_pixel(last_pixel),
    .last_flush(last_flush)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok)   state_d = ST_FEED;
      ST_FEED:  if (last_pixel) state_d = ST_FLUSH;
      ST_FLUSH: if (last_flush) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // The scan counter holds the position of the beat being formed this cycle;
  // it is copied into the output registers alongside the data it describes.
  always_comb begin
    s_ready       = (state_q == ST_FEED);
    busy          = (state_q != ST_IDLE);
    cnt_en        = busy;
    data_out_d    = (s_ready && s_valid) ? s_data : '0;
    row_count_d   = cnt_en ? pos_row : '0;
    col_count_d   = cnt_en ? pos_col : '0;
    beat_active_d = cnt_en;
    done_d        = (state_q == ST_FLUSH) && last_flush;
    row_lim_d     = start_ok ? row_in : row_lim_q;
    col_lim_d     = start_ok ? col_in : col_lim_q;

    err_d = err_q;
    if (start_bad || (s_ready && !s_valid)) err_d = 1'b1;
    if (start_ok)                           err_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_out_q    <= '0;
      row_count_q   <= '0;
      col_count_q   <= '0;
      beat_active_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      row_lim_q     <= '0;
      col_lim_q     <= '0;
    end else begin
      data_out_q    <= data_out_d;
      row_count_q   <= row_count_d;
      col_count_q   <= col_count_d;
      beat_active_q <= beat_active_d;
      done_q        <= done_d;
      err_q         <= err_d;
      row_lim_q     <= row_lim_d;
      col_lim_q     <= col_lim_d;
    end
  end

  assign data_out    = data_out_q;
  assign row_count   = row_count_q;
  assign col_count   = col_count_q;
  assign beat_active = beat_active_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_line_feed_ctrl.sv
// Directed bench for line_feed_ctrl: expected beats are queued as pixels are
// driven and checked off as the DUT emits them.
module tb_line_feed_ctrl;

  logic        Clk;
  logic        Rst_n;
  logic        start;
  logic [8:0]  row_in;
  logic [8:0]  col_in;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] data_out;
  logic [8:0]  row_count;
  logic [8:0]  col_count;
  logic        beat_active;
  logic        busy;
  logic        done;
  logic        err;

  line_feed_ctrl dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .start      (start),
    .row_in     (row_in),
    .col_in     (col_in),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .data_out   (data_out),
    .row_count  (row_count),
    .col_count  (col_count),
    .beat_active(beat_active),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [8:0]  row;
    logic [8:0]  col;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp      = 0;
  int n_bad      = 0;
  int beats_seen = 0;
  int exp_beats  = 0;
  int done_cnt   = 0;
  int exp_done   = 0;
  int frame_id   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && beat_active === 1'b1) begin
      beat_t e;
      beats_seen++;
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", data_out, e.data);
        check("beat_row", row_count, 64'(e.row));
        check("beat_col", col_count, 64'(e.col));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // Called on a falling edge in IDLE (or in the done cycle); returns on the
  // falling edge where done is observed.
  task automatic run_frame(input int rows, input int cols, input int gap_idx, input int restart_idx);
    beat_t e;
    logic [63:0] d;
    int total;
    bit got_done;
    start   = 1'b1;
    row_in  = 9'(rows);
    col_in  = 9'(cols);
    s_valid = 1'b0;
    s_data  = '0;
    @(negedge Clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err, 0);
    check("s_ready_feed", s_ready, 1);
    for (int i = 0; i < rows * cols; i++) begin
      d = (64'(frame_id) << 32) | 64'(i + 1);
      s_valid = (i != gap_idx);
      s_data  = d;
      e.data  = (i != gap_idx) ? d : 64'd0;
      e.row   = 9'(i % rows);
      e.col   = 9'(i / rows);
      exp_q.push_back(e);
      exp_beats++;
      if (i == restart_idx) begin
        start  = 1'b1;
        row_in = 9'd5;
        col_in = 9'd2;
      end else begin
        start  = 1'b0;
      end
      @(negedge Clk);
    end
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    total   = rows * cols;
    for (int j = 0; j < rows + 2; j++) begin
      e.data = '0;
      e.row  = 9'((total + j) % rows);
      e.col  = 9'((total + j) / rows);
      exp_q.push_back(e);
      exp_beats++;
    end
    check("s_ready_flush", s_ready, 0);
    got_done = 1'b0;
    for (int k = 0; k < rows + 8; k++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
    end
    check("done_seen", got_done, 1);
    check("busy_in_done_cycle", busy, 0);
    exp_done++;
    frame_id++;
  endtask

  task automatic frame_tail(input logic exp_err);
    @(negedge Clk);
    check("beats_total", beats_seen, exp_beats);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    check("idle_outputs", {data_out, row_count, col_count, beat_active, busy, done}, 0);
    check("err_after_frame", err, exp_err);
  endtask

  initial begin
    Rst_n   = 1'b0;
    start   = 1'b0;
    row_in  = '0;
    col_in  = '0;
    s_data  = '0;
    s_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_outputs", {data_out, row_count, col_count, beat_active, busy, done, err, s_ready}, 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // 4x3 frame, data 1..12, 18 beats ending at (1,4)
    run_frame(4, 3, -1, -1);
    frame_tail(1'b0);

    // illegal size: error, no beats, stays idle
    start  = 1'b1;
    row_in = 9'd3;
    col_in = 9'd3;
    @(negedge Clk);
    start = 1'b0;
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 0);
    repeat (4) @(negedge Clk);
    frame_tail(1'b1);

    // underrun on the fifth pixel: zero beat, err held until next start
    run_frame(4, 3, 4, -1);
    frame_tail(1'b1);
    repeat (3) @(negedge Clk);
    check("err_sticky", err, 1);

    // start pulsed mid-FEED is ignored
    run_frame(4, 3, -1, 5);
    frame_tail(1'b0);

    // asynchronous reset after the seventh beat
    start  = 1'b1;
    row_in = 9'd4;
    col_in = 9'd3;
    @(negedge Clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      beat_t e;
      s_valid = 1'b1;
      s_data  = 64'(100 + i);
      e.data  = 64'(100 + i);
      e.row   = 9'(i % 4);
      e.col   = 9'(i / 4);
      exp_q.push_back(e);
      exp_beats++;
      @(negedge Clk);
    end
    #1;
    s_valid = 1'b0;
    Rst_n   = 1'b0;
    #1;
    check("async_reset_outputs", {data_out, row_count, col_count, beat_active, busy, done, err, s_ready}, 0);
    check("reset_queue_empty", exp_q.size(), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // clean frame after reset
    run_frame(4, 3, -1, -1);
    frame_tail(1'b0);

    // tallest frame (col reaches 417) then back-to-back widest frame
    run_frame(4, 416, -1, -1);
    check("last_tall_row", row_count, 1);
    check("last_tall_col", col_count, 417);
    run_frame(416, 2, -1, -1);
    check("last_wide_row", row_count, 1);
    check("last_wide_col", col_count, 3);
    frame_tail(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
